// File: rtl/data_mem_controller.sv
// data_mem_controller: arbitrates per-thread LSU data-memory requests onto a
// fixed set of external memory channels. Each channel serves one consumer per
// transaction: it claims the consumer, issues the request, captures the reply
// and relays it until the LSU drops its request. Data is passed through as-is.
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 32,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_read_data,
    output logic [NUM_CHANNELS-1:0]                     mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                     mem_write_ready
);

    localparam int   IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic WR_EN    = (WRITE_ENABLE != 0);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        READ_RELAYING  = 3'd2,
        WRITE_WAITING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } chan_state_t;

    chan_state_t               state_r [NUM_CHANNELS];
    logic [IDX_BITS-1:0]       owner_r [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]  serving_r;

    logic [NUM_CHANNELS-1:0]   claim_en_s;
    logic [NUM_CHANNELS-1:0]   claim_write_s;
    logic [IDX_BITS-1:0]       claim_idx_s [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]  taken_s;
    logic                      found_s;

    // Claim arbitration: idle channels in ascending order each pick the lowest
    // unserved requesting consumer; picks made by lower channels this cycle
    // are excluded. A consumer asking for both read and write gets read first.
    always_comb begin
        taken_s       = serving_r;
        claim_en_s    = '0;
        claim_write_s = '0;
        found_s       = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            claim_idx_s[ch] = '0;
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found_s = 1'b0;
            if (state_r[ch] == IDLE) begin
                for (int c = 0; c < NUM_CONSUMERS; c++) begin
                    if (!found_s && !taken_s[c] &&
                        (consumer_read_valid[c] || (WR_EN && consumer_write_valid[c]))) begin
                        found_s            = 1'b1;
                        taken_s[c]         = 1'b1;
                        claim_en_s[ch]     = 1'b1;
                        claim_idx_s[ch]    = IDX_BITS'(c);
                        claim_write_s[ch]  = !consumer_read_valid[c];
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                claim_en_s[ch] = 1'b0;
            end
        end
    end

    // Per-channel request/relay state machines with registered memory-side
    // and consumer-side outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_r[ch] <= IDLE;
                owner_r[ch] <= '0;
            end
            serving_r            <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_r[ch])
                    IDLE: begin
                        if (claim_en_s[ch]) begin
                            owner_r[ch]                 <= claim_idx_s[ch];
                            serving_r[claim_idx_s[ch]]  <= 1'b1;
                            if (claim_write_s[ch]) begin
                                mem_write_valid[ch]   <= 1'b1;
                                mem_write_address[ch] <= consumer_write_address[claim_idx_s[ch]];
                                mem_write_data[ch]    <= consumer_write_data[claim_idx_s[ch]];
                                state_r[ch]           <= WRITE_WAITING;
                            end else begin
                                mem_read_valid[ch]    <= 1'b1;
                                mem_read_address[ch]  <= consumer_read_address[claim_idx_s[ch]];
                                state_r[ch]           <= READ_WAITING;
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]                   <= 1'b0;
                            consumer_read_ready[owner_r[ch]]     <= 1'b1;
                            consumer_read_data[owner_r[ch]]      <= mem_read_data[ch];
                            state_r[ch]                          <= READ_RELAYING;
                        end
                    end
                    READ_RELAYING: begin
                        if (!consumer_read_valid[owner_r[ch]]) begin
                            consumer_read_ready[owner_r[ch]] <= 1'b0;
                            serving_r[owner_r[ch]]           <= 1'b0;
                            state_r[ch]                      <= IDLE;
                        end
                    end
                    WRITE_WAITING: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch]               <= 1'b0;
                            consumer_write_ready[owner_r[ch]] <= 1'b1;
                            state_r[ch]                       <= WRITE_RELAYING;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!consumer_write_valid[owner_r[ch]]) begin
                            consumer_write_ready[owner_r[ch]] <= 1'b0;
                            serving_r[owner_r[ch]]            <= 1'b0;
                            state_r[ch]                       <= IDLE;
                        end
                    end
                    default: begin
                        mem_read_valid[ch]  <= 1'b0;
                        mem_write_valid[ch] <= 1'b0;
                        state_r[ch]         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Testbench for data_mem_controller: a behavioural memory with configurable
// latency/stall/random ready, LSU-style stimulus and directed plus randomized
// scenarios checked against an array-based memory model.
module tb_data_mem_controller;

    localparam int AB  = 8;
    localparam int DB  = 32;
    localparam int NC  = 8;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]           consumer_read_valid;
    logic [NC-1:0][AB-1:0]   consumer_read_address;
    logic [NC-1:0]           consumer_read_ready;
    logic [NC-1:0][DB-1:0]   consumer_read_data;
    logic [NC-1:0]           consumer_write_valid;
    logic [NC-1:0][AB-1:0]   consumer_write_address;
    logic [NC-1:0][DB-1:0]   consumer_write_data;
    logic [NC-1:0]           consumer_write_ready;
    logic [NCH-1:0]          mem_read_valid;
    logic [NCH-1:0][AB-1:0]  mem_read_address;
    logic [NCH-1:0]          mem_read_ready;
    logic [NCH-1:0][DB-1:0]  mem_read_data;
    logic [NCH-1:0]          mem_write_valid;
    logic [NCH-1:0][AB-1:0]  mem_write_address;
    logic [NCH-1:0][DB-1:0]  mem_write_data;
    logic [NCH-1:0]          mem_write_ready;

    always #5 clk = ~clk;

    data_mem_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready),
        .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready)
    );

    // Memory model and responder configuration
    logic [DB-1:0]  tbmem [256];
    logic           init_we;
    logic [AB-1:0]  init_addr;
    logic [DB-1:0]  init_data;
    int             rd_cnt [NCH];
    int             wr_cnt [NCH];
    int             lat;
    int unsigned    prob;
    logic [NCH-1:0] stall;
    logic [NCH-1:0] force_rd;
    logic           rd_ok;
    logic           wr_ok;

    int n_tests = 0;
    int n_fail  = 0;

    int rd_st [NC];
    int wr_st [NC];

    // Memory array updates and per-channel wait counters
    always @(posedge clk) begin
        if (init_we) tbmem[init_addr] <= init_data;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mem_write_valid[ch] && mem_write_ready[ch])
                tbmem[mem_write_address[ch]] <= mem_write_data[ch];
            if (reset || !mem_read_valid[ch] || mem_read_ready[ch]) rd_cnt[ch] <= 0;
            else rd_cnt[ch] <= rd_cnt[ch] + 1;
            if (reset || !mem_write_valid[ch] || mem_write_ready[ch]) wr_cnt[ch] <= 0;
            else wr_cnt[ch] <= wr_cnt[ch] + 1;
        end
    end

    // Memory responder: drives ready/data mid-cycle
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            rd_ok = mem_read_valid[ch] && (rd_cnt[ch] >= lat) && !stall[ch] &&
                    ($urandom_range(99, 0) < prob);
            mem_read_ready[ch] = rd_ok || force_rd[ch];
            mem_read_data[ch]  = rd_ok ? tbmem[mem_read_address[ch]] :
                                 (force_rd[ch] ? 32'hBAD0_BAD0 : $urandom);
            wr_ok = mem_write_valid[ch] && (wr_cnt[ch] >= lat) && !stall[ch] &&
                    ($urandom_range(99, 0) < prob);
            mem_write_ready[ch] = wr_ok;
        end
    end

    task automatic set_mem(input logic [AB-1:0] a, input logic [DB-1:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int a = 0; a < 256; a++) begin
            set_mem(AB'(a), $urandom);
        end
        @(negedge clk);
        n_tests++;
        if ({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_valids: got %h expected 0",
                     {mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready});
        end
        n_tests++;
        if ({mem_read_address, mem_write_address, mem_write_data, consumer_read_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: outputs not zero after reset");
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int k;
        logic [DB-1:0] exp;
        set_mem(8'h02, 32'h0040_0000);
        lat = 1; prob = 100;
        @(posedge clk); #1;
        consumer_read_address[0] = 8'h02; consumer_read_valid[0] = 1'b1;     // cycle 0
        @(negedge clk);
        n_tests++;
        if (mem_read_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_c0: mem_read_valid=%b expected 0000", mem_read_valid);
        end
        @(negedge clk);                                                       // cycle 1
        n_tests++;
        if (mem_read_valid !== 4'b0001 || mem_read_address[0] !== 8'h02) begin
            n_fail++; $display("FAIL single_c1: valid=%b addr=%h expected 0001/02", mem_read_valid, mem_read_address[0]);
        end
        @(negedge clk);                                                       // cycle 2
        n_tests++;
        if (mem_read_valid !== 4'b0001 || consumer_read_ready !== 8'h00) begin
            n_fail++; $display("FAIL single_c2: valid=%b ready=%b expected 0001/00", mem_read_valid, consumer_read_ready);
        end
        @(negedge clk);                                                       // cycle 3
        n_tests++;
        if (consumer_read_ready !== 8'h01 || consumer_read_data[0] !== 32'h0040_0000 || mem_read_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_c3: ready=%b data=%h mvalid=%b expected 01/00400000/0000",
                               consumer_read_ready, consumer_read_data[0], mem_read_valid);
        end
        @(negedge clk);                                                       // cycle 4
        n_tests++;
        if (consumer_read_ready !== 8'h01) begin
            n_fail++; $display("FAIL single_hold: ready=%b expected 01", consumer_read_ready);
        end
        @(posedge clk); #1;
        consumer_read_valid[0] = 1'b0;                                        // cycle 5
        @(negedge clk);
        @(posedge clk); #1;
        exp = tbmem[8'h03];
        consumer_read_address[0] = 8'h03; consumer_read_valid[0] = 1'b1;     // cycle 6
        @(negedge clk);
        n_tests++;
        if (consumer_read_ready !== 8'h00 || mem_read_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_release: ready=%b mvalid=%b expected 00/0000", consumer_read_ready, mem_read_valid);
        end
        @(negedge clk);                                                       // cycle 7
        n_tests++;
        if (mem_read_valid !== 4'b0001 || mem_read_address[0] !== 8'h03) begin
            n_fail++; $display("FAIL single_reclaim: valid=%b addr=%h expected 0001/03", mem_read_valid, mem_read_address[0]);
        end
        k = 0;
        while (consumer_read_ready[0] !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k >= 20 || consumer_read_data[0] !== exp) begin
            n_fail++; $display("FAIL single_second: data=%h expected %h (wait %0d)", consumer_read_data[0], exp, k);
        end
        @(posedge clk); #1;
        consumer_read_valid[0] = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_oversub();
        logic [DB-1:0] exp [NC];
        int rdy_cyc [NC];
        int c;
        int served;
        lat = 0; prob = 100;
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            consumer_read_address[i] = AB'(i);
            consumer_read_valid[i]   = 1'b1;
            exp[i]     = tbmem[i];
            rdy_cyc[i] = -1;
        end
        c = 0; served = 0;
        while (served < NC && c < 100) begin
            @(negedge clk);
            if (c == 1) begin
                n_tests++;
                if (mem_read_valid !== 4'hF ||
                    mem_read_address !== {8'd3, 8'd2, 8'd1, 8'd0}) begin
                    n_fail++; $display("FAIL oversub_claim: valid=%b addr=%h expected F/03020100",
                                       mem_read_valid, mem_read_address);
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (consumer_read_ready[i] && rdy_cyc[i] < 0) begin
                    rdy_cyc[i] = c; served++;
                    n_tests++;
                    if (consumer_read_data[i] !== exp[i] || c !== ((i < 4) ? 2 : 6)) begin
                        n_fail++; $display("FAIL oversub_c%0d: data=%h cycle=%0d expected %h cycle %0d",
                                           i, consumer_read_data[i], c, exp[i], (i < 4) ? 2 : 6);
                    end
                end
            end
            @(posedge clk); #1;
            c++;
            for (int i = 0; i < NC; i++) begin
                if (rdy_cyc[i] >= 0) consumer_read_valid[i] = 1'b0;
            end
        end
        n_tests++;
        if (served != NC) begin
            n_fail++; $display("FAIL oversub_timeout: served=%0d expected %0d", served, NC);
        end
        consumer_read_valid = '0;
        idle_cycles(3);
    endtask

    task automatic test_write();
        lat = 1; prob = 100;
        @(posedge clk); #1;
        consumer_write_address[5] = 8'h10;
        consumer_write_data[5]    = 32'hDEAD_BEEF;
        consumer_write_valid[5]   = 1'b1;                                     // cycle 0
        @(negedge clk);
        n_tests++;
        if (mem_write_valid !== 4'b0000) begin
            n_fail++; $display("FAIL write_c0: mem_write_valid=%b expected 0000", mem_write_valid);
        end
        @(posedge clk); #1;
        consumer_write_data[5] = 32'h1234_5678;                               // post-claim change
        @(negedge clk);                                                       // cycle 1
        n_tests++;
        if (mem_write_valid !== 4'b0001 || mem_write_address[0] !== 8'h10 ||
            mem_write_data[0] !== 32'hDEAD_BEEF || mem_read_valid !== 4'b0000) begin
            n_fail++; $display("FAIL write_c1: v=%b a=%h d=%h expected 0001/10/deadbeef",
                               mem_write_valid, mem_write_address[0], mem_write_data[0]);
        end
        @(negedge clk);                                                       // cycle 2
        @(negedge clk);                                                       // cycle 3
        n_tests++;
        if (consumer_write_ready !== 8'h20 || mem_write_valid !== 4'b0000 || tbmem[8'h10] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL write_c3: ready=%b mv=%b mem=%h expected 20/0000/deadbeef",
                               consumer_write_ready, mem_write_valid, tbmem[8'h10]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (consumer_write_ready !== 8'h20) begin
                n_fail++; $display("FAIL write_hold%0d: ready=%b expected 20", k, consumer_write_ready);
            end
        end
        @(posedge clk); #1;
        consumer_write_valid[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (consumer_write_ready !== 8'h00) begin
            n_fail++; $display("FAIL write_release: ready=%b expected 00", consumer_write_ready);
        end
        idle_cycles(2);
    endtask

    task automatic test_mixed();
        logic [AB-1:0] ra, wa;
        logic [DB-1:0] wd, exp;
        lat = 1; prob = 100;
        ra = AB'($urandom); wa = ra ^ 8'h80; wd = $urandom; exp = tbmem[ra];
        @(posedge clk); #1;
        consumer_read_address[1]  = ra; consumer_read_valid[1] = 1'b1;
        consumer_write_address[2] = wa; consumer_write_data[2] = wd; consumer_write_valid[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);                                                       // cycle 1
        n_tests++;
        if (mem_read_valid !== 4'b0001 || mem_read_address[0] !== ra ||
            mem_write_valid !== 4'b0010 || mem_write_address[1] !== wa || mem_write_data[1] !== wd) begin
            n_fail++; $display("FAIL mixed_req: rv=%b ra=%h wv=%b wa=%h wd=%h expected 0001/%h/0010/%h/%h",
                               mem_read_valid, mem_read_address[0], mem_write_valid,
                               mem_write_address[1], mem_write_data[1], ra, wa, wd);
        end
        @(negedge clk);
        @(negedge clk);                                                       // cycle 3
        n_tests++;
        if (consumer_read_ready !== 8'h02 || consumer_read_data[1] !== exp ||
            consumer_write_ready !== 8'h04 || tbmem[wa] !== wd) begin
            n_fail++; $display("FAIL mixed_done: rr=%b rd=%h wr=%b mem=%h expected 02/%h/04/%h",
                               consumer_read_ready, consumer_read_data[1], consumer_write_ready,
                               tbmem[wa], exp, wd);
        end
        @(posedge clk); #1;
        consumer_read_valid[1] = 1'b0; consumer_write_valid[2] = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_stall();
        logic [AB-1:0] a0, a1;
        logic [DB-1:0] e0, e1;
        int k;
        lat = 0; prob = 100; stall = 4'b0001;
        a0 = AB'($urandom); a1 = a0 ^ 8'h01; e0 = tbmem[a0]; e1 = tbmem[a1];
        @(posedge clk); #1;
        consumer_read_address[0] = a0; consumer_read_valid[0] = 1'b1;
        consumer_read_address[1] = a1; consumer_read_valid[1] = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_tests++;
                if (mem_read_valid[0] !== 1'b1 || mem_read_address[0] !== a0 || consumer_read_ready[0] !== 1'b0) begin
                    n_fail++; $display("FAIL stall_c%0d: v=%b a=%h r=%b expected 1/%h/0",
                                       c, mem_read_valid[0], mem_read_address[0], consumer_read_ready[0], a0);
                end
            end
            if (c == 2) begin
                n_tests++;
                if (consumer_read_ready[1] !== 1'b1 || consumer_read_data[1] !== e1) begin
                    n_fail++; $display("FAIL stall_other: ready=%b data=%h expected 1/%h",
                                       consumer_read_ready[1], consumer_read_data[1], e1);
                end
            end
            @(posedge clk); #1;
            if (c == 1) consumer_read_address[0] = ~a0;
            if (c == 2) consumer_read_valid[1] = 1'b0;
        end
        stall = 4'b0000;
        k = 0;
        while (consumer_read_ready[0] !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k >= 20 || consumer_read_data[0] !== e0) begin
            n_fail++; $display("FAIL stall_finish: data=%h expected %h (wait %0d)", consumer_read_data[0], e0, k);
        end
        @(posedge clk); #1;
        consumer_read_valid[0] = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_read();
        logic [AB-1:0] b;
        logic [DB-1:0] exp;
        int k;
        lat = 0; prob = 100; stall = 4'b0001;
        @(posedge clk); #1;
        consumer_read_address[0] = AB'($urandom); consumer_read_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_read_valid !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_waiting: valid=%b expected 0001", mem_read_valid);
        end
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1; consumer_read_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; stall = 4'b0000; force_rd = 4'b0001;
        @(negedge clk);
        n_tests++;
        if ({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready} !== '0 ||
            {mem_read_address, consumer_read_data} !== '0) begin
            n_fail++; $display("FAIL rstmid_zero: rv=%b rr=%b outputs not zero", mem_read_valid, consumer_read_ready);
        end
        @(posedge clk); #1;
        force_rd = 4'b0000;
        @(negedge clk);
        n_tests++;
        if (consumer_read_ready !== 8'h00 || consumer_read_data[0] !== 32'h0 || mem_read_valid !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_late: ready=%b data=%h expected 00/0", consumer_read_ready, consumer_read_data[0]);
        end
        b = AB'($urandom); exp = tbmem[b];
        @(posedge clk); #1;
        consumer_read_address[0] = b; consumer_read_valid[0] = 1'b1;
        k = 0;
        while (consumer_read_ready[0] !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k >= 20 || consumer_read_data[0] !== exp) begin
            n_fail++; $display("FAIL rstmid_fresh: data=%h expected %h (wait %0d)", consumer_read_data[0], exp, k);
        end
        @(posedge clk); #1;
        consumer_read_valid[0] = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic [AB-1:0] addr [NC];
        logic [DB-1:0] exp [NC];
        logic [DB-1:0] wd [NC];
        int busy, cyc, spurious, op;
        for (int r = 0; r < 40; r++) begin
            lat  = $urandom_range(3, 0);
            prob = $urandom_range(100, 30);
            @(posedge clk); #1;
            for (int i = 0; i < NC; i++) begin
                op = $urandom_range(3, 0);
                addr[i] = {5'($urandom), 3'(i)};
                exp[i]  = tbmem[addr[i]];
                wd[i]   = $urandom;
                rd_st[i] = (op == 1 || op == 3) ? 1 : 0;
                wr_st[i] = (op == 2 || op == 3) ? 1 : 0;
                consumer_read_address[i]  = addr[i];
                consumer_write_address[i] = addr[i];
                consumer_write_data[i]    = wd[i];
                consumer_read_valid[i]    = (rd_st[i] == 1);
                consumer_write_valid[i]   = (wr_st[i] == 1);
            end
            cyc = 0; spurious = 0; busy = 1;
            while (busy != 0 && cyc < 600) begin
                @(negedge clk);
                for (int i = 0; i < NC; i++) begin
                    if (rd_st[i] == 1 && consumer_read_ready[i]) begin
                        rd_st[i] = 2;
                        n_tests++;
                        if (consumer_read_data[i] !== exp[i]) begin
                            n_fail++; $display("FAIL rand_read r%0d c%0d: data=%h expected %h",
                                               r, i, consumer_read_data[i], exp[i]);
                        end
                    end else if (rd_st[i] == 3) rd_st[i] = 0;
                    else if (rd_st[i] == 0 && consumer_read_ready[i]) spurious++;
                    if (wr_st[i] == 1 && consumer_write_ready[i]) begin
                        wr_st[i] = 2;
                        n_tests++;
                        if (tbmem[addr[i]] !== wd[i] || rd_st[i] != 0) begin
                            n_fail++; $display("FAIL rand_write r%0d c%0d: mem=%h rd_state=%0d expected %h/0",
                                               r, i, tbmem[addr[i]], rd_st[i], wd[i]);
                        end
                    end else if (wr_st[i] == 3) wr_st[i] = 0;
                    else if (wr_st[i] == 0 && consumer_write_ready[i]) spurious++;
                end
                @(posedge clk); #1;
                cyc++;
                busy = 0;
                for (int i = 0; i < NC; i++) begin
                    if (rd_st[i] == 2) begin consumer_read_valid[i] = 1'b0; rd_st[i] = 3; end
                    if (wr_st[i] == 2) begin consumer_write_valid[i] = 1'b0; wr_st[i] = 3; end
                    if (rd_st[i] != 0 || wr_st[i] != 0) busy++;
                end
            end
            n_tests++;
            if (busy != 0 || spurious != 0) begin
                n_fail++; $display("FAIL rand_round r%0d: pending=%0d spurious=%0d expected 0/0", r, busy, spurious);
            end
            consumer_read_valid = '0; consumer_write_valid = '0;
            idle_cycles(2);
        end
    endtask

    initial begin
        reset = 1'b1;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        lat = 0; prob = 100; stall = '0; force_rd = '0;
        consumer_read_valid = '0; consumer_read_address = '0;
        consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
        test_reset();
        test_single_read();
        test_oversub();
        test_write();
        test_mixed();
        test_stall();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
Arbitrates data-memory requests from all thread LSUs (NUM_CORES × THREADS_PER_BLOCK consumers) onto the fixed set of external data-memory channels exposed at the gpu top level. Each channel runs its own request/relay state machine, and a channel serves exactly one consumer per transaction. Upstream it faces the per-thread LSUs; downstream it drives the data_mem_read_*/data_mem_write_* ports directly. The block is 32-bit fixed-point data clean: it passes data through and never modifies it.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 32, data word width (Q-format fixed point, passed through untouched)
NUM_CONSUMERS, 8, LSU count (2 cores × 4 threads)
NUM_CHANNELS, 4, external memory channels; must satisfy NUM_CHANNELS ≤ NUM_CONSUMERS
WRITE_ENABLE, 1, 0 removes the write path (write outputs tied 0, write FSM states unreachable)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
consumer_read_valid  in  [NUM_CONSUMERS]  LSU read request
consumer_read_address  in  [NUM_CONSUMERS]×ADDR_BITS  read address
consumer_read_ready  out  [NUM_CONSUMERS]  read data valid to LSU
consumer_read_data  out  [NUM_CONSUMERS]×DATA_BITS  returned word
consumer_write_valid  in  [NUM_CONSUMERS]  LSU write request
consumer_write_address  in  [NUM_CONSUMERS]×ADDR_BITS  write address
consumer_write_data  in  [NUM_CONSUMERS]×DATA_BITS  write word
consumer_write_ready  out  [NUM_CONSUMERS]  write complete to LSU
mem_read_valid  out  [NUM_CHANNELS]  channel read request
mem_read_address  out  [NUM_CHANNELS]×ADDR_BITS  channel read address
mem_read_ready  in  [NUM_CHANNELS]  memory read data valid this cycle
mem_read_data  in  [NUM_CHANNELS]×DATA_BITS  memory read word
mem_write_valid  out  [NUM_CHANNELS]  channel write request
mem_write_address  out  [NUM_CHANNELS]×ADDR_BITS  channel write address
mem_write_data  out  [NUM_CHANNELS]×DATA_BITS  channel write word
mem_write_ready  in  [NUM_CHANNELS]  memory write accepted this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. On any posedge with reset=1, every output and consumer_*_data goes to 0, every channel returns to IDLE, and the serving mask clears. Reset mid-transaction drops the transaction. A mem_*_ready that arrives after reset is ignored. The LSU must reissue the request.
- Per-channel FSM: IDLE → READ_WAITING / WRITE_WAITING → READ_RELAYING / WRITE_RELAYING → IDLE.
- Claim:
  - Channels are evaluated in ascending index within one cycle.
  - An IDLE channel claims the lowest-index consumer that has valid high and is not in the serving mask. That includes consumers claimed earlier in the same cycle by a lower channel.
  - On claim, the consumer's serving bit is set and its address/data are registered into the channel.
- Read path:
  - Claim edge (cycle N): mem_read_valid=1 from cycle N+1.
  - READ_WAITING holds valid and address until mem_read_ready=1. On that cycle, mem_read_data is captured and mem_read_valid drops next cycle.
  - READ_RELAYING: consumer_read_ready=1 and consumer_read_data holds the captured word until consumer_read_valid=0. The channel then returns to IDLE and the serving bit clears on the same edge.
- Write path: identical handshake using mem_write_valid/ready. consumer_write_ready is held until consumer_write_valid=0.
- Latency and throughput:
  - With memory ready in the first request cycle, the consumer sees ready 2 cycles after raising valid.
  - A channel accepts a new claim no sooner than the cycle after the consumer drops valid.
- Both read and write valid on one consumer: read is claimed first, write on a later claim.
- Stalls: memory ready held low stalls only that channel. Other channels proceed independently.
- More pending consumers than channels: the excess wait. There is no starvation bound beyond index priority, which is acceptable because LSUs retire.
- Address and data are registered at claim, so consumer-side changes after claim have no effect on the memory side.
- WRITE_ENABLE=0: consumer_write_ready=0 and mem_write_valid=0 permanently. Write requests are never claimed.

Test Plan:
- Single read: consumer 0 reads addr 0x02, mem returns 0x00400000 the cycle after valid → mem_read_valid cycles 1-2, consumer_read_ready from cycle 3 with data 0x00400000; channel idle one cycle after valid drops.
- Oversubscription: all 8 consumers read addr = index simultaneously, ready always 1 → consumers 0-3 served on channels 0-3 first, 4-7 after release; every consumer receives mem[index].
- Write: consumer 5 writes 0xDEADBEEF to 0x10 → mem_write_valid/address/data = 1/0x10/0xDEADBEEF on one channel; consumer_write_ready held until valid drops.
- Mixed: consumer 1 reads while consumer 2 writes in the same cycle → channel 0 serves 1 (read), channel 1 serves 2 (write), no cross-talk.
- Stall: channel 0 mem_read_ready held low 5 cycles while channel 1 completes → channel 1 consumer finishes first; channel 0 valid/address stable for the full stall.
- Reset mid-read in READ_WAITING → next cycle all outputs 0, late mem_read_ready ignored; a fresh request after reset completes normally.
